addr_share_arbiter: RTL and testbench
=====================================

# addr_share_arbiter

Round-robin arbiter and sequencer that shares one registered 8-bit adder between NUM_REQ requesters. It accepts operand pairs over per-requester valid/ready handshakes and drives the adder's operand and valid inputs. It then collects the adder's sum, carry and ready outputs and returns each result to the fabric tagged with the ID of the requester that issued it. It sits between the request fabric and a single adder instance, and serialises all add operations.

## Interface
- NUM_REQ, 4: number of requesters, 2..8.
- ID_W, 2: width of the requester ID; must satisfy 2**ID_W >= NUM_REQ.
- TIMEOUT, 15: maximum WAIT cycles allowed before an error response, 1..255.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  NUM_REQ  per-requester request valid.
- req_a  in  NUM_REQ*8  operand A; requester i uses bits [8i+7:8i].
- req_b  in  NUM_REQ*8  operand B, same packing as req_a.
- req_ready  out  NUM_REQ  one-hot accept strobe; combinational from state and req_valid.
- add_a  out  8  operand A to the adder (registered).
- add_b  out  8  operand B to the adder (registered).
- add_val  out  1  data-valid to the adder (registered).
- add_sum  in  8  sum result from the adder.
- add_carry  in  1  carry-out from the adder.
- add_ready  in  1  result-ready from the adder.
- rsp_valid  out  1  response valid; held until acknowledged.
- rsp_id  out  ID_W  requester index the response belongs to.
- rsp_sum  out  8  captured sum.
- rsp_carry  out  1  captured carry.
- rsp_err  out  1  set when the operation timed out.
- rsp_ack  in  1  downstream accept of the response.
- busy  out  1  high whenever state is not IDLE.

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP. Reset state is IDLE.
- IDLE:
  - If any req_valid is high, the winner g is the first set bit found searching upward from last_grant+1, wrapping at NUM_REQ.
  - req_ready[g]=1 during this cycle; all other req_ready bits are 0. Requester g is accepted on this edge.
  - Clock edge: add_a<=req_a[g], add_b<=req_b[g], add_val<=1, cur_id<=g, last_grant<=g, state->ISSUE.
  - With no req_valid high, the FSM stays in IDLE, req_ready=0 and all registers hold.
- ISSUE:
  - add_val=1 for exactly this one cycle; the adder samples the operands at the end of the cycle.
  - Edge: add_val<=0, wait counter<=0, state->WAIT.
- WAIT: each cycle, check add_ready.
  - If add_ready=1: rsp_sum<=add_sum, rsp_carry<=add_carry, rsp_err<=0, rsp_id<=cur_id, rsp_valid<=1, state->RESP.
  - Else if counter==TIMEOUT-1: rsp_sum<=0, rsp_carry<=0, rsp_err<=1, rsp_id<=cur_id, rsp_valid<=1, state->RESP.
  - Otherwise the counter increments.
- RESP:
  - rsp_valid, rsp_id, rsp_sum, rsp_carry and rsp_err are held stable.
  - On an edge with rsp_ack=1: rsp_valid<=0, state->IDLE.
  - New requests are not accepted in this state.
- Arithmetic is performed entirely by the external adder; this block never modifies add_sum or add_carry.
- req_ready is never asserted outside IDLE, and never asserted for a requester whose req_valid is low.
- A requester that deasserts req_valid before it is granted loses its request; the arbiter has no memory of it.
- rsp_ack is ignored when rsp_valid=0.

## Timing
- Reset values:
  - req_ready=0, add_a=0, add_b=0, add_val=0.
  - rsp_valid=0, rsp_id=0, rsp_sum=0, rsp_carry=0, rsp_err=0, busy=0.
  - last_grant=NUM_REQ-1, so requester 0 has the highest priority after reset.
- Reset asserted in any state clears all of the above immediately; an in-flight operation is discarded and no response is produced.
- Latency with a one-cycle adder:
  - Grant on edge 0, add_val high in cycle 1, add_ready seen in cycle 2.
  - rsp_valid high from cycle 3.
- Throughput with rsp_ack tied high: one operation per 4 cycles, and the next grant occurs in the cycle after RESP.
- Fairness: with all requesters continuously valid, the grant order is 0,1,2,...,NUM_REQ-1,0,...
- Timeout: the error response is raised TIMEOUT cycles after entry to WAIT.

## Test plan
- **Single request.** Reset, then req_valid[2]=1 with a=0x3C, b=0x05, and the adder returns sum=0x41, carry=0. Required: req_ready[2] for one cycle; add_val high for exactly one cycle; rsp_valid=1 with rsp_id=2, rsp_sum=0x41, rsp_carry=0, rsp_err=0 at grant+3.
- **Carry out.** a=0xFF, b=0x01 from requester 0. Required: rsp_sum=0x00, rsp_carry=1.
- **Round-robin fairness.** All four req_valid held high, rsp_ack=1. Required: grant sequence 0,1,2,3,0,1; a new grant every 4 cycles; each rsp_id matches its grant.
- **Backpressure.** rsp_ack held low for 10 cycles while other requests are pending. Required: response fields are stable, req_ready stays 0 and busy stays 1; after ack, the next grant goes to the next requester in round-robin order.
- **Timeout.** add_ready is never asserted and TIMEOUT=15. Required: rsp_valid with rsp_err=1, rsp_sum=0 after 15 WAIT cycles; the FSM then returns to IDLE after ack.
- **Reset mid-operation.** Assert reset during WAIT. Required: add_val=0, rsp_valid=0, busy=0 immediately; the first grant after reset goes to requester 0.

Source files
------------

// File: rtl/addr_share_arbiter.sv
// addr_share_arbiter: round-robin sequencer sharing one registered 8-bit adder among NUM_REQ requesters
module addr_share_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2,
    parameter int TIMEOUT = 15
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [NUM_REQ*8-1:0] req_a,
    input  logic [NUM_REQ*8-1:0] req_b,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic [7:0]           add_a,
    output logic [7:0]           add_b,
    output logic                 add_val,
    input  logic [7:0]           add_sum,
    input  logic                 add_carry,
    input  logic                 add_ready,
    output logic                 rsp_valid,
    output logic [ID_W-1:0]      rsp_id,
    output logic [7:0]           rsp_sum,
    output logic                 rsp_carry,
    output logic                 rsp_err,
    input  logic                 rsp_ack,
    output logic                 busy
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
    state_t state, state_nxt;
    logic [ID_W-1:0]    last_grant, cur_id, grant, off;
    logic [ID_W+1:0]    pos;
    logic [NUM_REQ-1:0] rot;
    logic [7:0]         wait_cnt;
    logic               any_req, expired;
    // rotate so bit 0 is the requester just after last_grant; lowest set bit wins
    assign rot = NUM_REQ'({req_valid, req_valid} >> ({1'b0, last_grant} + (ID_W+1)'(1)));
    always_comb begin
        off = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--)
            if (rot[i]) off = ID_W'(i);
    end
    assign pos       = (ID_W+2)'(last_grant) + (ID_W+2)'(off) + (ID_W+2)'(1);
    assign grant     = ID_W'(pos >= (ID_W+2)'(NUM_REQ) ? pos - (ID_W+2)'(NUM_REQ) : pos);
    assign any_req   = |req_valid;
    assign expired   = wait_cnt == 8'(TIMEOUT - 1);
    assign req_ready = (state == IDLE && any_req && !reset) ? NUM_REQ'(1) << grant : '0;
    assign busy      = state != IDLE;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = any_req ? ISSUE : IDLE;
            ISSUE:   state_nxt = WAIT;
            WAIT:    state_nxt = (add_ready || expired) ? RESP : WAIT;
            RESP:    state_nxt = rsp_ack ? IDLE : RESP;
            default: state_nxt = IDLE;
        endcase
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            add_a      <= '0;
            add_b      <= '0;
            add_val    <= 1'b0;
            cur_id     <= '0;
            last_grant <= ID_W'(NUM_REQ - 1);
            wait_cnt   <= '0;
            rsp_valid  <= 1'b0;
            rsp_id     <= '0;
            rsp_sum    <= '0;
            rsp_carry  <= 1'b0;
            rsp_err    <= 1'b0;
        end else begin
            case (state)
                IDLE: if (any_req) begin
                    add_a      <= req_a[{grant, 3'b000} +: 8];
                    add_b      <= req_b[{grant, 3'b000} +: 8];
                    add_val    <= 1'b1;
                    cur_id     <= grant;
                    last_grant <= grant;
                end
                ISSUE: begin
                    add_val  <= 1'b0;
                    wait_cnt <= '0;
                end
                WAIT: if (add_ready || expired) begin
                    rsp_sum   <= add_ready ? add_sum : 8'd0;
                    rsp_carry <= add_ready & add_carry;
                    rsp_err   <= !add_ready;
                    rsp_id    <= cur_id;
                    rsp_valid <= 1'b1;
                end else begin
                    wait_cnt <= wait_cnt + 8'd1;
                end
                RESP: if (rsp_ack) rsp_valid <= 1'b0;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_addr_share_arbiter.sv
// tb_addr_share_arbiter: directed table, hand sequences and randomized ops against a transaction-level model
module tb_addr_share_arbiter;
    localparam int N  = 4;
    localparam int TO = 15;

    logic          clk = 1'b0;
    logic          reset;
    logic [N-1:0]  req_valid, req_ready;
    logic [N*8-1:0] req_a, req_b;
    logic [7:0]    add_a, add_b, add_sum, rsp_sum;
    logic          add_val, add_carry, add_ready;
    logic          rsp_valid, rsp_carry, rsp_err, rsp_ack, busy;
    logic [1:0]    rsp_id;

    int checks = 0;
    int errors = 0;
    int lat_cfg = 1;
    int dly = 0;
    logic [8:0] add_res = '0;

    always #5 clk = ~clk;

    addr_share_arbiter #(.NUM_REQ(N), .ID_W(2), .TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
        .req_ready(req_ready), .add_a(add_a), .add_b(add_b), .add_val(add_val),
        .add_sum(add_sum), .add_carry(add_carry), .add_ready(add_ready),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_sum(rsp_sum), .rsp_carry(rsp_carry),
        .rsp_err(rsp_err), .rsp_ack(rsp_ack), .busy(busy)
    );

    // external adder: result ready lat_cfg cycles after it samples add_val; lat_cfg 0 never answers
    always @(posedge clk) begin
        if (reset) dly <= 0;
        else if (add_val) begin
            add_res <= {1'b0, add_a} + {1'b0, add_b};
            dly     <= lat_cfg;
        end else if (dly > 0) dly <= dly - 1;
    end
    assign add_ready = dly == 1;
    assign add_sum   = add_res[7:0];
    assign add_carry = add_res[8];

    typedef struct {
        logic [3:0] mask;
        logic [7:0] a, b;
        int         lat, ackd, id;
        logic [7:0] sum;
        logic       car, err;
    } vec_t;
    vec_t tbl [8];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    task automatic do_op(input logic [3:0] mask, input logic [31:0] av, input logic [31:0] bv,
                         input int lat, input int ackd, input int eid,
                         input logic [7:0] esum, input logic ecar, input logic eerr);
        int n, extra, stray, bad;
        logic [12:0] snap;
        @(negedge clk);
        req_valid = mask; req_a = av; req_b = bv; lat_cfg = lat;
        #1;
        chk("idle_busy", busy, 0);
        chk("grant", req_ready, 32'(1) << eid);
        @(negedge clk);
        chk("add_val", add_val, 1);
        chk("add_a", add_a, av[8*eid +: 8]);
        chk("add_b", add_b, bv[8*eid +: 8]);
        chk("busy", busy, 1);
        n = 1; extra = 0; stray = 0;
        while (!rsp_valid && n < 40) begin
            @(negedge clk);
            n++;
            if (add_val) extra++;
            if (req_ready != 0) stray++;
        end
        chk("add_val_once", extra, 0);
        chk("ready_while_busy", stray, 0);
        chk("latency", n, eerr ? TO + 2 : lat + 2);
        chk("rsp_valid", rsp_valid, 1);
        chk("rsp_id", rsp_id, eid);
        chk("rsp_sum", rsp_sum, esum);
        chk("rsp_carry", rsp_carry, ecar);
        chk("rsp_err", rsp_err, eerr);
        snap = {rsp_valid, rsp_id, rsp_sum, rsp_carry, rsp_err};
        bad = 0;
        repeat (ackd) begin
            @(negedge clk);
            if (snap != {rsp_valid, rsp_id, rsp_sum, rsp_carry, rsp_err} || req_ready != 0 || !busy) bad++;
        end
        if (ackd > 0) chk("hold", bad, 0);
        rsp_ack = 1'b1; req_valid = '0;
        @(negedge clk);
        rsp_ack = 1'b0;
        chk("ack_valid", rsp_valid, 0);
        chk("ack_busy", busy, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        logic [31:0] av, bv;
        int last, win, g, c, nresp, lastc, lat;
        logic [3:0] mask;
        logic [8:0] s;
        int q[$];
        tbl[0] = '{4'b0100, 8'h3C, 8'h05, 1,  0,  2, 8'h41, 1'b0, 1'b0};
        tbl[1] = '{4'b0001, 8'hFF, 8'h01, 1,  0,  0, 8'h00, 1'b1, 1'b0};
        tbl[2] = '{4'b1111, 8'h10, 8'h20, 2,  10, 1, 8'h30, 1'b0, 1'b0};
        tbl[3] = '{4'b0101, 8'h80, 8'h80, 15, 1,  2, 8'h00, 1'b1, 1'b0};
        tbl[4] = '{4'b0011, 8'h01, 8'h02, 16, 0,  0, 8'h00, 1'b0, 1'b1};
        tbl[5] = '{4'b1001, 8'h7F, 8'h01, 0,  2,  3, 8'h00, 1'b0, 1'b1};
        tbl[6] = '{4'b1000, 8'hAA, 8'h55, 3,  0,  3, 8'hFF, 1'b0, 1'b0};
        tbl[7] = '{4'b1110, 8'hC8, 8'h64, 1,  0,  1, 8'h2C, 1'b1, 1'b0};
        reset = 1'b1; req_valid = '0; req_a = '0; req_b = '0; rsp_ack = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_add_val", add_val, 0);
        chk("rst_add_a", add_a, 0);
        reset = 1'b0;
        #1;
        chk("rst_ready", req_ready, 0);
        chk("rst_add_b", add_b, 0);
        chk("rst_rsp", {rsp_valid, rsp_id, rsp_sum, rsp_carry, rsp_err}, 0);
        chk("rst_busy", busy, 0);

        foreach (tbl[k]) begin
            av = $urandom; bv = $urandom;
            av[8*tbl[k].id +: 8] = tbl[k].a;
            bv[8*tbl[k].id +: 8] = tbl[k].b;
            do_op(tbl[k].mask, av, bv, tbl[k].lat, tbl[k].ackd, tbl[k].id,
                  tbl[k].sum, tbl[k].car, tbl[k].err);
        end

        // reset during WAIT discards the operation
        @(negedge clk);
        req_valid = 4'b0010; lat_cfg = 0; req_a = 32'h1234_5678; req_b = 32'h1111_1111;
        #1;
        chk("mid_grant", req_ready, 4'b0010);
        repeat (4) @(negedge clk);
        chk("mid_busy_before", busy, 1);
        reset = 1'b1;
        #1;
        chk("mid_add_val", add_val, 0);
        chk("mid_rsp_valid", rsp_valid, 0);
        chk("mid_busy", busy, 0);
        chk("mid_ready", req_ready, 0);
        @(negedge clk);
        reset = 1'b0; req_valid = 4'b1111; rsp_ack = 1'b1; lat_cfg = 1;

        // fairness with everyone valid and ack tied high; first grant after reset is 0
        g = 0; c = 0; nresp = 0; lastc = 0;
        while (!(g == 6 && nresp == 6) && c < 60) begin
            #1;
            if (req_ready != 0) begin
                chk("fair_grant", req_ready, 32'(1) << (g % N));
                if (g > 0) chk("fair_period", c - lastc, 4);
                q.push_back(g % N);
                lastc = c;
                g++;
            end
            if (rsp_valid) begin
                chk("fair_rsp_id", rsp_id, q.size() > 0 ? q.pop_front() : 99);
                chk("fair_rsp_err", rsp_err, 0);
                nresp++;
            end
            @(negedge clk);
            c++;
            if (g >= 6) req_valid = '0;
        end
        chk("fair_grants", g, 6);
        chk("fair_resps", nresp, 6);
        rsp_ack = 1'b0;

        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        last = N - 1;
        repeat (60) begin
            mask = 4'($urandom_range(0, 15));
            av = $urandom; bv = $urandom;
            lat = $urandom_range(0, 18);
            if (mask == 0) begin
                @(negedge clk);
                req_valid = '0;
                #1;
                chk("rnd_idle_ready", req_ready, 0);
                chk("rnd_idle_busy", busy, 0);
            end else begin
                win = -1;
                for (int k = 1; k <= N; k++)
                    if (win < 0 && mask[(last + k) % N]) win = (last + k) % N;
                last = win;
                s = {1'b0, av[8*win +: 8]} + {1'b0, bv[8*win +: 8]};
                if (lat == 0 || lat > TO)
                    do_op(mask, av, bv, lat, $urandom_range(0, 3), win, 8'h00, 1'b0, 1'b1);
                else
                    do_op(mask, av, bv, lat, $urandom_range(0, 3), win, s[7:0], s[8], 1'b0);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
